// File: rtl/cnn_pkg.sv
// Shared types and sizing helpers for the CNN front-end window generator.
package cnn_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} swg_state_t;

   function automatic int unsigned win_idx(input int unsigned i, input int unsigned j,
                                           input int unsigned k);
      return i * k + j;
   endfunction

   function automatic int unsigned padded_dim(input int unsigned dim, input int unsigned pad);
      return dim + 2 * pad;
   endfunction

   function automatic int unsigned win_count(input int unsigned img_w, input int unsigned img_h,
                                             input int unsigned k, input int unsigned pad);
      return (padded_dim(img_h, pad) - k + 1) * (padded_dim(img_w, pad) - k + 1);
   endfunction

endpackage

// File: rtl/ff_line_buffer.sv
// Register-based shift line; tap returns the sample shifted in DEPTH enables earlier.
module ff_line_buffer #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned DEPTH  = 30
) (
   input  logic              clk,
   input  logic              shift_en,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] tap
);

   logic [DATA_W-1:0] line [DEPTH];

   always_ff @(posedge clk) begin
      if (shift_en) begin
         line[0] <= din;
         for (int unsigned i = 1; i < DEPTH; i++) begin
            line[i] <= line[i-1];
         end
      end
   end

   assign tap = line[DEPTH-1];

endmodule

// File: rtl/stream_window_gen.sv
// Streaming KxK window generator with internal zero padding over a raster pixel stream.
module stream_window_gen
   import cnn_pkg::*;
#(
   parameter int unsigned IN_W   = 8,
   parameter int unsigned DATA_W = 16,
   parameter int unsigned IMG_W  = 28,
   parameter int unsigned IMG_H  = 28,
   parameter int unsigned K      = 3,
   parameter int unsigned PAD    = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [IN_W-1:0]       pixel_i,
   input  logic                  pixel_i_valid,
   output logic                  pixel_i_ready,
   output logic [K*K*DATA_W-1:0] win_o,
   output logic                  win_o_valid,
   input  logic                  win_o_ready,
   output logic                  win_o_last,
   output logic                  frame_done_o
);

   localparam int unsigned WP   = padded_dim(IMG_W, PAD);
   localparam int unsigned HP   = padded_dim(IMG_H, PAD);
   localparam int unsigned PC_W = $clog2(WP);
   localparam int unsigned PR_W = $clog2(HP);
   localparam logic [PC_W-1:0] PC_LAST = PC_W'(WP - 1);
   localparam logic [PR_W-1:0] PR_LAST = PR_W'(HP - 1);
   localparam logic [PC_W-1:0] PC_WIN  = PC_W'(K - 1);
   localparam logic [PR_W-1:0] PR_WIN  = PR_W'(K - 1);

   swg_state_t        state;
   logic [PC_W-1:0]   pc;
   logic [PR_W-1:0]   pr;
   logic              row_in, col_in_rng, interior, out_free, step, emit_pos, last_pos;
   logic [DATA_W-1:0] sample;
   logic [DATA_W-1:0] lb_tap  [K-1];
   logic [DATA_W-1:0] col_in  [K];
   logic [DATA_W-1:0] win_r   [K][K];
   logic [DATA_W-1:0] win_nx  [K][K];
   logic [K*K*DATA_W-1:0] win_nx_flat;

   if (PAD == 0) begin : g_nopad
      assign row_in     = 1'b1;
      assign col_in_rng = 1'b1;
   end else begin : g_pad
      localparam logic [PC_W-1:0] PC_LO = PC_W'(PAD);
      localparam logic [PC_W-1:0] PC_HI = PC_W'(WP - PAD - 1);
      localparam logic [PR_W-1:0] PR_LO = PR_W'(PAD);
      localparam logic [PR_W-1:0] PR_HI = PR_W'(HP - PAD - 1);
      assign row_in     = (pr >= PR_LO) && (pr <= PR_HI);
      assign col_in_rng = (pc >= PC_LO) && (pc <= PC_HI);
   end

   assign interior      = row_in && col_in_rng;
   assign out_free      = !win_o_valid || win_o_ready;
   assign step          = (state == RUN) && out_free && (interior ? pixel_i_valid : 1'b1);
   assign pixel_i_ready = (state == RUN) && interior && out_free;
   assign emit_pos      = (pr >= PR_WIN) && (pc >= PC_WIN);
   assign last_pos      = (pr == PR_LAST) && (pc == PC_LAST);
   assign sample        = interior ? DATA_W'(pixel_i) : '0;

   // Chain: line buffer m delays the stream by m+1 padded rows.
   for (genvar m = 0; m < K-1; m++) begin : g_lb
      logic [DATA_W-1:0] lb_din;
      if (m == 0) begin : g_head
         assign lb_din = sample;
      end else begin : g_link
         assign lb_din = lb_tap[m-1];
      end
      ff_line_buffer #(.DATA_W(DATA_W), .DEPTH(WP)) u_lb (
         .clk      (clk),
         .shift_en (step),
         .din      (lb_din),
         .tap      (lb_tap[m])
      );
   end

   // Bottom window row takes the live sample; rows above take progressively older taps.
   always_comb begin
      col_in[K-1] = sample;
      for (int unsigned m = 0; m < K-1; m++) begin
         col_in[K-2-m] = lb_tap[m];
      end
      for (int unsigned i = 0; i < K; i++) begin
         for (int unsigned j = 0; j < K-1; j++) begin
            win_nx[i][j] = win_r[i][j+1];
         end
         win_nx[i][K-1] = col_in[i];
      end
      win_nx_flat = '0;
      for (int unsigned i = 0; i < K; i++) begin
         for (int unsigned j = 0; j < K; j++) begin
            win_nx_flat[win_idx(i, j, K)*DATA_W +: DATA_W] = win_nx[i][j];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (step) win_r <= win_nx;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= IDLE;
         pc           <= '0;
         pr           <= '0;
         win_o        <= '0;
         win_o_valid  <= 1'b0;
         win_o_last   <= 1'b0;
         frame_done_o <= 1'b0;
      end else begin
         frame_done_o <= 1'b0;
         if (step && emit_pos) begin
            win_o       <= win_nx_flat;
            win_o_valid <= 1'b1;
            win_o_last  <= last_pos;
         end else if (win_o_ready) begin
            win_o_valid <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (pixel_i_valid) begin
                  state <= RUN;
                  pc    <= '0;
                  pr    <= '0;
               end
            end
            RUN: begin
               if (step) begin
                  if (pc == PC_LAST) begin
                     pc <= '0;
                     if (pr == PR_LAST) begin
                        pr    <= '0;
                        state <= DRAIN;
                     end else begin
                        pr <= pr + 1'b1;
                     end
                  end else begin
                     pc <= pc + 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (win_o_valid && win_o_ready && win_o_last) begin
                  frame_done_o <= 1'b1;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_stream_window_gen.sv
// Self-checking bench for stream_window_gen: 4x4 frames, K=3, PAD=1 and PAD=0 instances.
module tb_stream_window_gen;

   localparam int unsigned IN_W   = 8;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned IW     = 4;
   localparam int unsigned IH     = 4;
   localparam int unsigned K      = 3;
   localparam int unsigned NPIX   = IW * IH;
   localparam int unsigned WW     = K * K * DATA_W;

   typedef logic [WW-1:0]   win_t;
   typedef logic [IN_W-1:0] frame_t [NPIX];
   typedef int              vals_t  [K*K];

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [IN_W-1:0] a_pix = '0, b_pix = '0;
   logic a_pv = 1'b0, b_pv = 1'b0, a_wr = 1'b1, b_wr = 1'b1;
   logic a_prdy, b_prdy, a_wv, b_wv, a_wl, b_wl, a_fd, b_fd;
   win_t a_win, b_win;
   bit   a_rnd = 1'b0;

   stream_window_gen #(.IN_W(IN_W), .DATA_W(DATA_W), .IMG_W(IW), .IMG_H(IH), .K(K), .PAD(1)) dut_pad1 (
      .clk(clk), .rst(rst), .pixel_i(a_pix), .pixel_i_valid(a_pv), .pixel_i_ready(a_prdy),
      .win_o(a_win), .win_o_valid(a_wv), .win_o_ready(a_wr), .win_o_last(a_wl), .frame_done_o(a_fd));

   stream_window_gen #(.IN_W(IN_W), .DATA_W(DATA_W), .IMG_W(IW), .IMG_H(IH), .K(K), .PAD(0)) dut_pad0 (
      .clk(clk), .rst(rst), .pixel_i(b_pix), .pixel_i_valid(b_pv), .pixel_i_ready(b_prdy),
      .win_o(b_win), .win_o_valid(b_wv), .win_o_ready(b_wr), .win_o_last(b_wl), .frame_done_o(b_fd));

   int checks   = 0;
   int failures = 0;

   win_t a_cap[$], b_cap[$], exp_win[$];
   bit   a_cap_last[$], b_cap_last[$], exp_last[$];
   int   a_fd_cnt = 0, b_fd_cnt = 0, a_acc = 0, b_acc = 0;

   task automatic check_eq(input string tag, input win_t obs, input win_t exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst && a_wv && a_wr) begin a_cap.push_back(a_win); a_cap_last.push_back(a_wl); end
      if (rst && b_wv && b_wr) begin b_cap.push_back(b_win); b_cap_last.push_back(b_wl); end
      if (a_fd) a_fd_cnt++;
      if (b_fd) b_fd_cnt++;
      if (a_pv && a_prdy) a_acc++;
      if (b_pv && b_prdy) b_acc++;
   end

   always @(posedge clk) begin
      #1;
      if (a_rnd) a_wr = 1'($urandom_range(0, 1));
   end

   // Reference: every window position of the padded frame, out-of-image taps read as zero.
   function automatic void model_frame(input int pad, input frame_t fr);
      int   hp, wp, y, x;
      win_t w;
      hp = IH + 2 * pad;
      wp = IW + 2 * pad;
      for (int r = 0; r <= hp - int'(K); r++) begin
         for (int c = 0; c <= wp - int'(K); c++) begin
            w = '0;
            for (int i = 0; i < int'(K); i++) begin
               for (int j = 0; j < int'(K); j++) begin
                  y = r + i - pad;
                  x = c + j - pad;
                  if (y >= 0 && y < int'(IH) && x >= 0 && x < int'(IW))
                     w[(i*K+j)*DATA_W +: DATA_W] = DATA_W'(fr[y*IW+x]);
               end
            end
            exp_win.push_back(w);
            exp_last.push_back(r == hp - int'(K) && c == wp - int'(K));
         end
      end
   endfunction

   function automatic win_t mk_win(input vals_t v);
      win_t w = '0;
      for (int unsigned n = 0; n < K*K; n++) w[n*DATA_W +: DATA_W] = DATA_W'(v[n]);
      return w;
   endfunction

   function automatic logic rdy(input int u);
      return (u == 0) ? a_prdy : b_prdy;
   endfunction

   function automatic int fd_cnt(input int u);
      return (u == 0) ? a_fd_cnt : b_fd_cnt;
   endfunction

   function automatic int acc_cnt(input int u);
      return (u == 0) ? a_acc : b_acc;
   endfunction

   task automatic set_in(input int u, input logic [IN_W-1:0] pix, input logic pv);
      if (u == 0) begin a_pix = pix; a_pv = pv; end
      else        begin b_pix = pix; b_pv = pv; end
   endtask

   task automatic clear_caps(input int u);
      if (u == 0) begin a_cap.delete(); a_cap_last.delete(); end
      else        begin b_cap.delete(); b_cap_last.delete(); end
   endtask

   // Called just after a rising edge; returns just after the edge that accepted the last pixel.
   task automatic drive(input int u, input frame_t fr, input int npix, input int gap);
      int n;
      for (int k = 0; k < npix; k++) begin
         if (gap > 0) repeat ($urandom_range(0, gap)) begin
            set_in(u, '0, 1'b0);
            @(posedge clk); #1;
         end
         set_in(u, fr[k], 1'b1);
         n = 0;
         @(negedge clk);
         while (!rdy(u) && n < 1000) begin @(negedge clk); n++; end
         if (!rdy(u)) begin
            check_eq("accept_timeout", win_t'(rdy(u)), win_t'(1));
            set_in(u, '0, 1'b0);
            return;
         end
         @(posedge clk); #1;
      end
      set_in(u, '0, 1'b0);
   endtask

   task automatic wait_fd(input int u, input int target);
      int n = 0;
      while (fd_cnt(u) < target && n < 1000) begin @(negedge clk); n++; end
      if (fd_cnt(u) < target) check_eq("frame_done_timeout", win_t'(fd_cnt(u)), win_t'(target));
      @(posedge clk); #1;
   endtask

   task automatic compare_caps(input int u, input string tag);
      int   n_obs;
      win_t w;
      bit   l;
      n_obs = (u == 0) ? a_cap.size() : b_cap.size();
      check_eq({tag, "_count"}, win_t'(n_obs), win_t'(exp_win.size()));
      for (int n = 0; n < exp_win.size() && n < n_obs; n++) begin
         w = (u == 0) ? a_cap[n] : b_cap[n];
         l = (u == 0) ? a_cap_last[n] : b_cap_last[n];
         check_eq($sformatf("%s_win%0d", tag, n), w, exp_win[n]);
         check_eq($sformatf("%s_last%0d", tag, n), win_t'(l), win_t'(exp_last[n]));
      end
   endtask

   task automatic run_frame(input int u, input frame_t fr, input int gap, input string tag);
      int fd0, acc0;
      clear_caps(u);
      exp_win.delete();
      exp_last.delete();
      model_frame((u == 0) ? 1 : 0, fr);
      fd0  = fd_cnt(u);
      acc0 = acc_cnt(u);
      drive(u, fr, NPIX, gap);
      wait_fd(u, fd0 + 1);
      repeat (4) @(posedge clk);
      #1;
      check_eq({tag, "_fd_pulses"}, win_t'(fd_cnt(u) - fd0), win_t'(1));
      check_eq({tag, "_pixels"}, win_t'(acc_cnt(u) - acc0), win_t'(NPIX));
      compare_caps(u, tag);
   endtask

   task automatic stall_a();
      int   n = 0;
      win_t held;
      @(negedge clk);
      while (a_cap.size() < 5 && n < 1000) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      a_wr = 1'b0;
      @(negedge clk);
      n = 0;
      while (!a_wv && n < 20) begin @(negedge clk); n++; end
      held = a_win;
      check_eq("t3_stall_valid", win_t'(a_wv), win_t'(1));
      repeat (10) begin
         @(negedge clk);
         check_eq("t3_stall_hold", a_win, held);
         check_eq("t3_stall_valid_hold", win_t'(a_wv), win_t'(1));
         check_eq("t3_stall_pix_rdy", win_t'(a_prdy), win_t'(0));
      end
      @(posedge clk); #1;
      a_wr = 1'b1;
   endtask

   task automatic check_idle_outputs(input string tag);
      check_eq({tag, "_win"}, a_win, '0);
      check_eq({tag, "_valid"}, win_t'(a_wv), win_t'(0));
      check_eq({tag, "_last"}, win_t'(a_wl), win_t'(0));
      check_eq({tag, "_done"}, win_t'(a_fd), win_t'(0));
      check_eq({tag, "_pix_rdy"}, win_t'(a_prdy), win_t'(0));
   endtask

   initial begin
      frame_t f1, f2, fr;
      int     fd0;
      for (int i = 0; i < int'(NPIX); i++) begin
         f1[i] = IN_W'(i + 1);
         f2[i] = IN_W'(101 + i);
      end

      rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle_outputs("reset");
      check_eq("reset_b_valid", win_t'(b_wv), win_t'(0));
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;

      // Test 1: PAD=1, continuous stream, consumer always ready
      run_frame(0, f1, 0, "t1");
      if (a_cap.size() == 16) begin
         check_eq("t1_first", a_cap[0], mk_win('{0, 0, 0, 0, 1, 2, 0, 5, 6}));
         check_eq("t1_w11", a_cap[5], mk_win('{1, 2, 3, 5, 6, 7, 9, 10, 11}));
         check_eq("t1_lastwin", a_cap[15], mk_win('{11, 12, 0, 15, 16, 0, 0, 0, 0}));
      end

      // Test 2: PAD=0
      run_frame(1, f1, 0, "t2");
      if (b_cap.size() == 4) begin
         check_eq("t2_w0", b_cap[0], mk_win('{1, 2, 3, 5, 6, 7, 9, 10, 11}));
         check_eq("t2_w1", b_cap[1], mk_win('{2, 3, 4, 6, 7, 8, 10, 11, 12}));
         check_eq("t2_w3", b_cap[3], mk_win('{6, 7, 8, 10, 11, 12, 14, 15, 16}));
      end

      // Test 3: consumer stall mid-frame
      fork
         run_frame(0, f1, 0, "t3");
         stall_a();
      join

      // Test 4: random gaps on the input stream
      run_frame(0, f1, 3, "t4");

      // Test 5: back-to-back frames
      clear_caps(0);
      exp_win.delete();
      exp_last.delete();
      model_frame(1, f1);
      model_frame(1, f2);
      fd0 = a_fd_cnt;
      drive(0, f1, NPIX, 0);
      drive(0, f2, NPIX, 0);
      wait_fd(0, fd0 + 2);
      repeat (4) @(posedge clk);
      #1;
      check_eq("t5_fd_pulses", win_t'(a_fd_cnt - fd0), win_t'(2));
      compare_caps(0, "t5");
      if (a_cap.size() == 32)
         check_eq("t5_f2_first", a_cap[16], mk_win('{0, 0, 0, 0, 101, 102, 0, 105, 106}));

      // Test 6: reset after 7 accepted pixels, then a clean frame
      drive(0, f1, 7, 0);
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check_idle_outputs("t6_after_rst");
      @(posedge clk); #1;
      run_frame(0, f1, 0, "t6");

      // Random frames with random input gaps and random consumer back-pressure
      a_rnd = 1'b1;
      for (int t = 0; t < 3; t++) begin
         for (int i = 0; i < int'(NPIX); i++) fr[i] = IN_W'($urandom_range(0, 255));
         run_frame(0, fr, 2, $sformatf("rnd%0d", t));
      end
      a_rnd = 1'b0;
      @(posedge clk); #1;
      a_wr = 1'b1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "global timeout");
   end

endmodule
